// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush,
// capture-time WB bypass and EX/MEM > MEM/WB operand forwarding.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rs_data,
   input  logic [XLEN-1:0] id_rt_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_use_imm,
   input  logic [2:0]      id_alu_control,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   output logic            id_ready,
   input  logic            flush,
   input  logic            exmem_reg_write,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_alu_out,
   input  logic            memwb_reg_write,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_control,
   output logic [XLEN-1:0] ex_store_data,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read
);
   logic            r_valid, r_use_imm, r_reg_write, r_mem_read;
   logic [REGW-1:0] r_rs, r_rt, r_rd;
   logic [XLEN-1:0] r_rs_data, r_rt_data, r_imm;
   logic [2:0]      r_alu_control;
   logic            w_hazard, w_wb_rs, w_wb_rt;
   logic            w_em_fwd_rs, w_em_fwd_rt, w_wb_fwd_rs, w_wb_fwd_rt;
   logic [XLEN-1:0] w_fwd_rs, w_fwd_rt;

   assign w_hazard = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                     ((r_rd == id_rs) | ((r_rd == id_rt) & ~id_use_imm));
   assign id_ready = ~w_hazard | flush;

   // Register-file write and read in the same cycle: take the written value.
   assign w_wb_rs = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == id_rs);
   assign w_wb_rt = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == id_rt);

   always_ff @(posedge clk) begin
      if (reset || flush || w_hazard) begin
         r_valid       <= 1'b0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_rd          <= '0;
         r_rs_data     <= '0;
         r_rt_data     <= '0;
         r_imm         <= '0;
         r_use_imm     <= 1'b0;
         r_alu_control <= '0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
      end else begin
         r_valid       <= id_valid;
         r_rs          <= id_rs;
         r_rt          <= id_rt;
         r_rd          <= id_rd;
         r_rs_data     <= w_wb_rs ? memwb_data : id_rs_data;
         r_rt_data     <= w_wb_rt ? memwb_data : id_rt_data;
         r_imm         <= id_imm;
         r_use_imm     <= id_use_imm;
         r_alu_control <= id_alu_control;
         r_reg_write   <= id_valid & id_reg_write;
         r_mem_read    <= id_valid & id_mem_read;
      end
   end

   assign w_em_fwd_rs = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == r_rs);
   assign w_em_fwd_rt = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == r_rt);
   assign w_wb_fwd_rs = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == r_rs);
   assign w_wb_fwd_rt = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == r_rt);

   always_comb begin
      w_fwd_rs      = w_em_fwd_rs ? exmem_alu_out : w_wb_fwd_rs ? memwb_data : r_rs_data;
      w_fwd_rt      = w_em_fwd_rt ? exmem_alu_out : w_wb_fwd_rt ? memwb_data : r_rt_data;
      alu_a         = r_valid ? w_fwd_rs : '0;
      alu_b         = r_valid ? (r_use_imm ? r_imm : w_fwd_rt) : '0;
      ex_store_data = r_valid ? w_fwd_rt : '0;
      alu_control   = r_valid ? r_alu_control : 3'b000;
   end

   assign ex_valid     = r_valid;
   assign ex_rd        = r_rd;
   assign ex_reg_write = r_reg_write;
   assign ex_mem_read  = r_mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of forwarding, load-use stall, flush,
// reset and capture bypass for id_ex_stage.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_use_imm;
   logic [2:0]  id_alu_control;
   logic        id_reg_write, id_mem_read, id_ready, flush;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_alu_out;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_data;
   logic        ex_valid;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_control;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_ready(id_ready), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; flush = 0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_use_imm = 0; id_alu_control = 0; id_reg_write = 0; id_mem_read = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_alu_out = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
   endtask

   task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic ui, input logic [2:0] op, input logic rw, input logic mr);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
      id_imm = imm; id_use_imm = ui; id_alu_control = op; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      step();
      reset = 0;
      #1;
      vectors++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_rd, alu_control} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl got v=%b rw=%b mr=%b rd=%0d op=%b need all 0",
                  ex_valid, ex_reg_write, ex_mem_read, ex_rd, alu_control);
      end
      vectors++;
      if ({alu_a, alu_b, ex_store_data} !== 96'd0) begin
         miscompares++;
         $display("FAIL reset_data got a=%h b=%h sd=%h need 0", alu_a, alu_b, ex_store_data);
      end
      vectors++;
      if (id_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready got %b need 1", id_ready);
      end
   endtask

   task automatic test_exmem_fwd();
      idle();
      present(3, 4, 8, 32'h0, 32'h5, 32'h0, 0, 3'b000, 1, 0);
      step();
      idle();
      exmem_reg_write = 1; exmem_rd = 3; exmem_alu_out = 32'h10;
      #1;
      vectors++;
      if (alu_a !== 32'h10 || alu_b !== 32'h5 || alu_control !== 3'b000) begin
         miscompares++;
         $display("FAIL exmem_fwd got a=%h b=%h op=%b need 10 5 000", alu_a, alu_b, alu_control);
      end
      vectors++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0) begin
         miscompares++;
         $display("FAIL exmem_ctrl got v=%b rd=%0d rw=%b mr=%b need 1 8 1 0",
                  ex_valid, ex_rd, ex_reg_write, ex_mem_read);
      end
      present(4, 3, 9, 32'h7, 32'h1, 32'hFFFF_FFF0, 1, 3'b001, 1, 0);
      step();
      idle();
      exmem_reg_write = 1; exmem_rd = 3; exmem_alu_out = 32'h22;
      #1;
      vectors++;
      if (alu_a !== 32'h7 || alu_b !== 32'hFFFF_FFF0 || ex_store_data !== 32'h22 || alu_control !== 3'b001) begin
         miscompares++;
         $display("FAIL imm_sel got a=%h b=%h sd=%h op=%b need 7 fffffff0 22 001",
                  alu_a, alu_b, ex_store_data, alu_control);
      end
   endtask

   task automatic test_priority();
      idle();
      present(5, 5, 6, 32'h1, 32'h2, 32'h0, 0, 3'b100, 1, 0);
      step();
      idle();
      exmem_reg_write = 1; exmem_rd = 5; exmem_alu_out = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'hBB;
      #1;
      vectors++;
      if (alu_a !== 32'hAA || alu_b !== 32'hAA || ex_store_data !== 32'hAA || alu_control !== 3'b100) begin
         miscompares++;
         $display("FAIL prio_exmem got a=%h b=%h sd=%h op=%b need aa aa aa 100",
                  alu_a, alu_b, ex_store_data, alu_control);
      end
      exmem_reg_write = 0;
      #1;
      vectors++;
      if (alu_a !== 32'hBB || alu_b !== 32'hBB) begin
         miscompares++;
         $display("FAIL prio_memwb got a=%h b=%h need bb bb", alu_a, alu_b);
      end
      exmem_reg_write = 1; exmem_rd = 0;
      #1;
      vectors++;
      if (alu_a !== 32'hBB || alu_b !== 32'hBB) begin
         miscompares++;
         $display("FAIL prio_exmem_r0 got a=%h b=%h need bb bb", alu_a, alu_b);
      end
      memwb_reg_write = 0; exmem_reg_write = 0;
      #1;
      vectors++;
      if (alu_a !== 32'h1 || alu_b !== 32'h2) begin
         miscompares++;
         $display("FAIL no_fwd got a=%h b=%h need 1 2", alu_a, alu_b);
      end
   endtask

   task automatic test_reg0();
      idle();
      present(0, 1, 2, 32'h0, 32'h9, 32'h0, 0, 3'b010, 1, 0);
      step();
      idle();
      exmem_reg_write = 1; exmem_rd = 0; exmem_alu_out = 32'hFFFF_FFFF;
      memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h77;
      #1;
      vectors++;
      if (alu_a !== 32'h0 || alu_b !== 32'h9 || alu_control !== 3'b010) begin
         miscompares++;
         $display("FAIL reg0 got a=%h b=%h op=%b need 0 9 010", alu_a, alu_b, alu_control);
      end
   endtask

   task automatic load_then_dependent();
      idle();
      present(1, 0, 7, 32'd100, 32'h0, 32'h4, 1, 3'b000, 1, 1);
      step();
      present(7, 2, 9, 32'hDEAD, 32'h3, 32'h0, 0, 3'b000, 1, 0);
      #1;
   endtask

   task automatic test_load_use();
      load_then_dependent();
      vectors++;
      if (id_ready !== 1'b0 || ex_mem_read !== 1'b1 || alu_a !== 32'd100 || alu_b !== 32'h4) begin
         miscompares++;
         $display("FAIL lu_stall got rdy=%b mr=%b a=%h b=%h need 0 1 64 4",
                  id_ready, ex_mem_read, alu_a, alu_b);
      end
      step();
      vectors++;
      if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || id_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL lu_bubble got v=%b mr=%b rw=%b rdy=%b need 0 0 0 1",
                  ex_valid, ex_mem_read, ex_reg_write, id_ready);
      end
      step();
      idle();
      memwb_reg_write = 1; memwb_rd = 7; memwb_data = 32'h1234;
      #1;
      vectors++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || alu_a !== 32'h1234 || alu_b !== 32'h3) begin
         miscompares++;
         $display("FAIL lu_fwd got v=%b rd=%0d a=%h b=%h need 1 9 1234 3",
                  ex_valid, ex_rd, alu_a, alu_b);
      end
      vectors++;
      if (id_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL lu_no_repeat got rdy=%b need 1", id_ready);
      end
   endtask

   task automatic test_flush();
      load_then_dependent();
      flush = 1;
      #1;
      vectors++;
      if (id_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_ready got %b need 1", id_ready);
      end
      step();
      flush = 0;
      #1;
      vectors++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || alu_a !== 32'h0) begin
         miscompares++;
         $display("FAIL flush_bubble got v=%b rw=%b mr=%b a=%h need 0 0 0 0",
                  ex_valid, ex_reg_write, ex_mem_read, alu_a);
      end
   endtask

   task automatic test_reset_stall_bypass();
      load_then_dependent();
      vectors++;
      if (id_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_pre_stall got %b need 0", id_ready);
      end
      reset = 1;
      step();
      reset = 0;
      #1;
      vectors++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_rd, alu_control} !== 11'd0 ||
          {alu_a, alu_b, ex_store_data} !== 96'd0 || id_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_stall got v=%b rw=%b mr=%b rd=%0d op=%b a=%h b=%h sd=%h rdy=%b need zeros rdy=1",
                  ex_valid, ex_reg_write, ex_mem_read, ex_rd, alu_control, alu_a, alu_b, ex_store_data, id_ready);
      end
      idle();
      present(2, 2, 4, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 0);
      memwb_reg_write = 1; memwb_rd = 2; memwb_data = 32'h55;
      step();
      idle();
      #1;
      vectors++;
      if (alu_a !== 32'h55 || alu_b !== 32'h55 || ex_store_data !== 32'h55) begin
         miscompares++;
         $display("FAIL capture_bypass got a=%h b=%h sd=%h need 55 55 55", alu_a, alu_b, ex_store_data);
      end
      present(0, 3, 4, 32'h0, 32'h6, 32'h0, 0, 3'b000, 1, 0);
      memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h99;
      step();
      idle();
      #1;
      vectors++;
      if (alu_a !== 32'h0 || alu_b !== 32'h6) begin
         miscompares++;
         $display("FAIL bypass_r0 got a=%h b=%h need 0 6", alu_a, alu_b);
      end
   endtask

   initial begin
      test_reset();
      test_exmem_fwd();
      test_priority();
      test_reg0();
      test_load_use();
      test_flush();
      test_reset_stall_bypass();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It registers one decoded instruction per cycle, resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's `A`, `B` and 3-bit `ALUControl` inputs. A load-use hazard stalls decode for exactly one cycle and inserts a bubble. It also supports a branch flush.

## Interface

Parameters:
- `XLEN`, default 32: datapath width.
- `REGW`, default 5: register index width.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode presents an instruction.
- `id_rs`, `id_rt`, `id_rd` in `REGW`: source and destination indices.
- `id_rs_data`, `id_rt_data` in `XLEN`: register-file read data.
- `id_imm` in `XLEN`: sign-extended immediate.
- `id_use_imm` in 1: `B` operand is the immediate, not `rt`.
- `id_alu_control` in 3: `000` add, `001` sub, `010` and, `100` or, `011` nor.
- `id_reg_write` in 1: instruction writes `rd`.
- `id_mem_read` in 1: instruction is a load.
- `id_ready` out 1: stage accepts the decode instruction this cycle (0 = stall decode).
- `flush` in 1: discard the decode instruction and load a bubble.
- `exmem_reg_write` in 1, `exmem_rd` in `REGW`, `exmem_alu_out` in `XLEN`: EX/MEM producer.
- `memwb_reg_write` in 1, `memwb_rd` in `REGW`, `memwb_data` in `XLEN`: MEM/WB producer (also the register-file write port).
- `ex_valid` out 1: the EX slot holds a real instruction.
- `alu_a`, `alu_b` out `XLEN`: ALU operands.
- `alu_control` out 3: ALU opcode.
- `ex_store_data` out `XLEN`: forwarded `rt` value, for stores.
- `ex_rd` out `REGW`, `ex_reg_write` out 1, `ex_mem_read` out 1: control passed to EX/MEM.

## Operation

**Registered EX slot.** Holds `valid`, `rs`, `rt`, `rd`, `rs_data`, `rt_data`, `imm`, `use_imm`, `alu_control`, `reg_write` and `mem_read`.

**Load-use hazard.** `hazard` = `ex_valid & ex_mem_read & (ex_rd != 0) & id_valid`, AND (`ex_rd == id_rs`, or `ex_rd == id_rt` with `id_use_imm` = 0).
- `id_ready` = `~hazard | flush`.

**Next-state priority** (highest first):
1. `reset`: every slot field cleared to 0.
2. `flush`: bubble. `valid`, `reg_write` and `mem_read` are 0; the other fields are don't-care but held at 0.
3. `hazard`: bubble, same as for `flush`. Decode holds its instruction.
4. Otherwise: capture all `id_*` fields, with `valid` = `id_valid`. If `id_valid` = 0, the control bits are forced to 0.

**Capture-time WB bypass.** If `memwb_reg_write` = 1, `memwb_rd` != 0 and `memwb_rd == id_rs`, then `rs_data` captures `memwb_data` instead of `id_rs_data`. The same rule applies to `rt`. This closes the same-cycle write/read gap at the register file.

**Output-side forwarding** (combinational from slot registers and producer ports), shown for `rs`; `rt` is identical:
- `fwd_rs` = `exmem_alu_out` if `exmem_reg_write` and `exmem_rd` != 0 and `exmem_rd == rs`.
- Else `memwb_data` if `memwb_reg_write` and `memwb_rd` != 0 and `memwb_rd == rs`.
- Else `rs_data`.
- EX/MEM always wins over MEM/WB.
- Register 0 is never forwarded, and never bypassed at capture.

**Outputs.**
- `alu_a` = `fwd_rs`.
- `alu_b` = `use_imm ? imm : fwd_rt`.
- `ex_store_data` = `fwd_rt`.
- When `valid` = 0, `alu_a`, `alu_b` and `ex_store_data` are forced to 0 and `alu_control` = `000`.
- `ex_rd`, `ex_reg_write` and `ex_mem_read` come straight from the slot.

There is no downstream backpressure: the EX slot advances every cycle.

## Timing

- **Latency:** decode to `alu_a`/`alu_b` is 1 cycle. Forwarding adds no cycles (combinational).
- **Reset values:** after the reset edge, `ex_valid`, `ex_reg_write` and `ex_mem_read` are 0; `ex_rd` = 0; `alu_a`, `alu_b` and `ex_store_data` are 0; `alu_control` = `000`; `id_ready` = 1.
- **Reset mid-stall:** `reset` overrides `hazard` and `flush`. On the next cycle `id_ready` = 1 and the slot is empty.
- **Load-use:**
  - Cycle N: the load is in EX and a dependent instruction is in ID, so `id_ready` = 0.
  - N+1: a bubble is in EX and the load is in MEM. The hazard is now false, so the dependent instruction is captured.
  - N+2: the dependent instruction is in EX and gets its operand from `memwb_data`.
  - The stall is exactly 1 cycle and never repeats for the same pair.
- **`flush` with `hazard`:** `flush` wins. A bubble is loaded and `id_ready` = 1.
- **Same register from both producers:** the EX/MEM value is used. If EX/MEM's `rd` is 0, the MEM/WB value is used.
- **`rs == rt`:** both operands forward independently from the same source.

## Test plan

1. **EX/MEM forward:** EX/MEM holds `rd` = 3 with `exmem_alu_out` = `0x10`. Decode presents `rs` = 3, `rt` = 4 (`id_rt_data` = 5), op `000`. Next cycle: `alu_a` = `0x10`, `alu_b` = 5, `alu_control` = `000`.
2. **Producer priority:** EX/MEM writes r5 = `0xAA` and MEM/WB writes r5 = `0xBB`, with slot `rs` = `rt` = 5. Required: `alu_a` = `alu_b` = `0xAA`. Drop `exmem_reg_write` and both become `0xBB`.
3. **Register 0:** `exmem_rd` = 0 with `exmem_alu_out` = `0xFFFF_FFFF`, slot `rs` = 0 and `rs_data` = 0. Required: `alu_a` = 0.
4. **Load-use:** the EX slot holds a load to r7 and decode presents `rs` = 7. Required:
   - `id_ready` = 0 for exactly one cycle, with `ex_valid` = 0 in the following cycle.
   - One cycle later, `memwb_data` = `0x1234` to r7 yields `alu_a` = `0x1234`.
5. **Flush during stall:** repeat scenario 4 with `flush` = 1 in the hazard cycle. Required: `id_ready` = 1, `ex_valid` = 0 next cycle, and `ex_reg_write` = 0.
6. **Reset mid-stall and capture bypass:**
   - Assert `reset` while `id_ready` = 0. Next cycle: all outputs are 0 and `id_ready` = 1.
   - Then capture with `memwb_rd` = `id_rs` = 2 and `memwb_data` = `0x55`, while `id_rs_data` is stale at 0. Required: `alu_a` = `0x55`.
